// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the sort design.
//   SORT_ADDR_W / SORT_DATA_W : sort RAM geometry (256 x 8).
//   REQ_LOAD / REQ_SORT / REQ_DISP : requester indices at the RAM arbiter.
//   arb_state_t : arbiter ownership state (OPEN or LOCKED to one requester).
package sort_pkg;

  localparam int SORT_ADDR_W = 8;
  localparam int SORT_DATA_W = 8;

  localparam int REQ_LOAD = 0;
  localparam int REQ_SORT = 1;
  localparam int REQ_DISP = 2;

  typedef enum logic [0:0] {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sort_arb_pick.sv
// sort_arb_pick: combinational winner selection for the sort RAM arbiter.
//   req [NUM_REQ]  : pending requests.
//   ptr [PTR_W]    : round-robin search start (ignored in the fixed build).
//   win [NUM_REQ]  : one-hot winner, zero when req is zero.
// Build option: define SORT_ARB_RR_EN for round-robin search starting at ptr;
// otherwise the lowest requesting index wins.
module sort_arb_pick
  import sort_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win
);

`ifdef SORT_ARB_RR_EN
  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk ptr, ptr+1, ... (mod NUM_REQ); the first requester seen wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic found;
  logic unused_ptr;

  // Fixed priority has no search start; ptr is tied off by the parent.
  assign unused_ptr = ^ptr;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sort_mem_arbiter.sv
// sort_mem_arbiter: shares the single-port sort RAM between the loader (0),
// the bubble-sort engine (1) and the HEX/LEDR readback (2).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset.
//   req/lock/we         : per-requester request, keep-ownership, write select.
//   addr/wdata          : flattened per-requester address and write data.
//   gnt                 : one-hot grant (combinational).
//   rvalid/rdata        : tagged read return, RD_LAT cycles after the grant.
//   mem_addr/mem_wren/mem_data, mem_q : RAM interface.
//   busy                : LOCKED or a read in flight.
//   lock_err            : one-cycle pulse when an idle lock is force-released.
// Build option: SORT_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority, lowest index wins).
//
// Handshake: a requester holds req (with we/addr/wdata/lock stable) until it
// sees gnt; the access happens in the cycle where req[i] & gnt[i] is high, and
// the requester may change its inputs in the following cycle. There is no
// back-pressure on rvalid: the requester must accept it when it pulses.
module sort_mem_arbiter
  import sort_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = SORT_ADDR_W,
  parameter int DATA_W       = SORT_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wren,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_q,
  output logic                      busy,
  output logic                      lock_err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t         state;
  logic [ID_W-1:0]    owner;
  logic [CNT_W-1:0]   idle_cnt;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] pick_win;

  logic               granted;
  logic [ID_W-1:0]    gidx;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;
  logic               g_we;
  logic               g_lock;
  logic [ADDR_W-1:0]  last_addr;
  logic [DATA_W-1:0]  last_data;

  logic [RD_LAT-1:0]  pv;
  logic [ID_W-1:0]    pid [RD_LAT];

`ifdef SORT_ARB_RR_EN
  logic [ID_W-1:0] ptr_q;

  // Pointer moves past the winner on every OPEN grant; frozen while LOCKED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state == OPEN && granted) begin
      ptr_q <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  sort_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win)
  );

  // While LOCKED only the owner can win; everyone else stalls.
  always_comb begin
    gnt = '0;
    if (state == LOCKED) begin
      gnt[owner] = req[owner];
    end else begin
      gnt = pick_win;
    end
  end

  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_we   = 1'b0;
    g_lock = 1'b0;
    gidx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_addr = addr[i*ADDR_W +: ADDR_W];
        g_data = wdata[i*DATA_W +: DATA_W];
        g_we   = we[i];
        g_lock = lock[i];
        gidx   = ID_W'(i);
      end
    end
  end

  assign granted  = |gnt;
  assign mem_wren = granted & g_we;
  // Address/data bus parks on the last granted access when idle.
  assign mem_addr = granted ? g_addr : last_addr;
  assign mem_data = granted ? g_data : last_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (granted) begin
      last_addr <= g_addr;
      last_data <= g_data;
    end
  end

  // Ownership FSM. The idle check fires on the cycle whose increment would
  // bring the counter to LOCK_TIMEOUT, so the release happens after exactly
  // LOCK_TIMEOUT idle owner cycles and lock_err is seen alongside OPEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OPEN;
      owner    <= '0;
      idle_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state)
        OPEN: begin
          idle_cnt <= '0;
          if (granted && g_lock) begin
            state <= LOCKED;
            owner <= gidx;
          end
        end
        LOCKED: begin
          if (!lock[owner]) begin
            state    <= OPEN;
            idle_cnt <= '0;
          end else if (req[owner]) begin
            idle_cnt <= '0;
          end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state    <= OPEN;
            lock_err <= 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state    <= OPEN;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  // Read tag pipeline: the last stage lines up with mem_q for that read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pid[i] <= '0;
      end
    end else begin
      pv[0]  <= granted & ~g_we;
      pid[0] <= gidx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (pv[RD_LAT-1]) begin
      rvalid[pid[RD_LAT-1]] = 1'b1;
    end
  end

  assign rdata = pv[RD_LAT-1] ? mem_q : '0;
  assign busy  = (state == LOCKED) | (|pv);

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// tb_sort_mem_arbiter: bench for sort_mem_arbiter with a behavioural 256x8
// registered-input RAM. Honours SORT_ARB_RR_EN for the arbitration order.
module tb_sort_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int RD_LAT  = 1;
`ifdef SORT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] we;
    logic [7:0] a0, a1, a2;
    logic [7:0] d0, d1, d2;
    logic [2:0] exp_gnt;
    int         exp_busy;   // -1: not checked
    int         exp_lerr;   // -1: not checked
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req, lock, we;
  logic [23:0] addr, wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_addr, mem_data, mem_q;
  logic        mem_wren, busy, lock_err;

  sort_mem_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ADDR_W       (8),
    .DATA_W       (8),
    .RD_LAT       (RD_LAT),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .mem_data (mem_data),
    .mem_q    (mem_q),
    .busy     (busy),
    .lock_err (lock_err)
  );

  function automatic logic [7:0] init_val(int i);
    logic [7:0] v;
    v = 8'(i * 37 + 11);
    if (i == 8'h05) v = 8'hA3;
    if (i == 8'h10) v = 8'h40;
    if (i == 8'h11) v = 8'h20;
    return v;
  endfunction

  // behavioural sort RAM: registered inputs, one-cycle read latency
  logic [7:0] ram [256];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      mem_q <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {due_cycle[15:0], id[1:0], data[7:0]}
  logic [25:0] exp_q[$];
  logic [7:0]  shadow [256];
  logic [7:0]  last_gaddr;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // output monitor: every cycle either the due read returns or rvalid is idle
  logic [25:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0][25:10] == 16'(cyc)) begin
        mon_e = exp_q.pop_front();
        chk("rvalid", {29'b0, rvalid}, 32'(3'b001 << mon_e[9:8]));
        chk("rdata", {24'b0, rdata}, {24'b0, mon_e[7:0]});
      end else begin
        chk("rvalid_idle", {29'b0, rvalid}, 32'b0);
      end
    end
  end

  function automatic vec_t mk(logic [2:0] r, logic [2:0] l, logic [2:0] w,
                              logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                              logic [7:0] d0, logic [7:0] d1, logic [7:0] d2,
                              logic [2:0] eg, int eb, int el);
    vec_t v;
    v.req = r; v.lock = l; v.we = w;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.exp_gnt = eg; v.exp_busy = eb; v.exp_lerr = el;
    return v;
  endfunction

  // driver: enter just after a posedge, drive, check mid-cycle, return after next posedge
  task automatic drive_cycle(input vec_t v, input string name);
    int         id;
    logic [7:0] wa;
    req = v.req; lock = v.lock; we = v.we;
    addr  = {v.a2, v.a1, v.a0};
    wdata = {v.d2, v.d1, v.d0};
    @(negedge clk);
    chk({name, "_gnt"}, {29'b0, gnt}, {29'b0, v.exp_gnt});
    if (v.exp_busy >= 0) chk({name, "_busy"}, {31'b0, busy}, 32'(v.exp_busy));
    if (v.exp_lerr >= 0) chk({name, "_lock_err"}, {31'b0, lock_err}, 32'(v.exp_lerr));
    if (v.exp_gnt == 3'b000) begin
      chk({name, "_wren_idle"}, {31'b0, mem_wren}, 32'b0);
      chk({name, "_addr_hold"}, {24'b0, mem_addr}, {24'b0, last_gaddr});
    end else begin
      id = v.exp_gnt[0] ? 0 : (v.exp_gnt[1] ? 1 : 2);
      wa = addr[id*8 +: 8];
      last_gaddr = wa;
      chk({name, "_mem_addr"}, {24'b0, mem_addr}, {24'b0, wa});
      chk({name, "_mem_wren"}, {31'b0, mem_wren}, {31'b0, we[id]});
      if (we[id]) begin
        chk({name, "_mem_data"}, {24'b0, mem_data}, {24'b0, wdata[id*8 +: 8]});
        shadow[wa] = wdata[id*8 +: 8];
      end else begin
        exp_q.push_back({16'(cyc + RD_LAT), 2'(id), shadow[wa]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_gnt"},      {29'b0, gnt},      32'b0);
    chk({name, "_rvalid"},   {29'b0, rvalid},   32'b0);
    chk({name, "_rdata"},    {24'b0, rdata},    32'b0);
    chk({name, "_mem_wren"}, {31'b0, mem_wren}, 32'b0);
    chk({name, "_mem_addr"}, {24'b0, mem_addr}, 32'b0);
    chk({name, "_mem_data"}, {24'b0, mem_data}, 32'b0);
    chk({name, "_busy"},     {31'b0, busy},     32'b0);
    chk({name, "_lock_err"}, {31'b0, lock_err}, 32'b0);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    rst = 1'b1;
    exp_q.delete();
    last_gaddr = '0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t t2 [6];
  vec_t t3 [7];
  vec_t idle;
  logic [7:0] ra0, ra1, ra2;

  initial begin
    rst = 1'b1;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    // vector tables
    ra0 = 8'($urandom_range(8'h30, 8'h3F));
    ra1 = 8'($urandom_range(8'h40, 8'h4F));
    ra2 = 8'($urandom_range(8'h50, 8'h5F));
    for (int i = 0; i < 6; i++) begin
      t2[i] = mk(3'b111, 3'b000, 3'b000, ra0, ra1, ra2, 8'h0, 8'h0, 8'h0,
                 RR ? 3'(3'b001 << (i % 3)) : 3'b001, (i == 0) ? 0 : 1, 0);
    end
    t3[0] = mk(3'b010, 3'b010, 3'b000, 8'h30, 8'h10, 8'h32, 8'h0, 8'h00, 8'h0, 3'b010, 0, 0);
    t3[1] = mk(3'b111, 3'b010, 3'b000, 8'h30, 8'h11, 8'h32, 8'h0, 8'h00, 8'h0, 3'b010, 1, 0);
    t3[2] = mk(3'b111, 3'b010, 3'b010, 8'h30, 8'h11, 8'h32, 8'h0, 8'h40, 8'h0, 3'b010, 1, 0);
    t3[3] = mk(3'b111, 3'b000, 3'b010, 8'h30, 8'h10, 8'h32, 8'h0, 8'h20, 8'h0, 3'b010, 1, 0);
    t3[4] = mk(3'b101, 3'b000, 3'b000, 8'h30, 8'h00, 8'h30, 8'h0, 8'h00, 8'h0,
               RR ? 3'b100 : 3'b001, 0, 0);
    t3[5] = mk(3'b010, 3'b000, 3'b000, 8'h00, 8'h10, 8'h00, 8'h0, 8'h00, 8'h0, 3'b010, 1, 0);
    t3[6] = mk(3'b010, 3'b000, 3'b000, 8'h00, 8'h11, 8'h00, 8'h0, 8'h00, 8'h0, 3'b010, 1, 0);
    idle  = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h0, 8'h00, 8'h0, 3'b000, -1, 0);

    // 1: single readback read, latency and data
    do_reset();
    drive_cycle(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'h05, 8'h0, 8'h0, 8'h0, 3'b100, 0, 0), "t1_read");
    drive_cycle(idle, "t1_idle");
    chk("t1_a3_seen", {24'b0, shadow[8'h05]}, 32'hA3);

    // 2: all three reading continuously
    do_reset();
    for (int i = 0; i < 6; i++) drive_cycle(t2[i], "t2");
    drive_cycle(idle, "t2_drain");

    // 3: locked compare-swap with competing requesters, then readback
    do_reset();
    for (int i = 0; i < 7; i++) drive_cycle(t3[i], "t3");
    drive_cycle(idle, "t3_drain");
    chk("t3_swap_lo", {24'b0, shadow[8'h10]}, 32'h20);
    chk("t3_swap_hi", {24'b0, shadow[8'h11]}, 32'h40);

    // 4: abandoned lock is force-released after 16 idle owner cycles
    do_reset();
    drive_cycle(mk(3'b010, 3'b010, 3'b000, 8'h00, 8'h40, 8'h00, 8'h0, 8'h0, 8'h0, 3'b010, 0, 0), "t4_lock");
    for (int i = 0; i < 16; i++) begin
      drive_cycle(mk(3'b001, 3'b010, 3'b000, 8'h05, 8'h40, 8'h00, 8'h0, 8'h0, 8'h0, 3'b000, 1, 0), "t4_stall");
    end
    drive_cycle(mk(3'b001, 3'b010, 3'b000, 8'h05, 8'h40, 8'h00, 8'h0, 8'h0, 8'h0, 3'b001, 0, 1), "t4_timeout");
    drive_cycle(mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h0, 8'h0, 8'h0, 3'b000, 1, 0), "t4_after");

    // 5: write then read-after-write from another requester
    do_reset();
    drive_cycle(mk(3'b001, 3'b000, 3'b001, 8'h22, 8'h00, 8'h00, 8'h7F, 8'h0, 8'h0, 3'b001, 0, 0), "t5_write");
    drive_cycle(mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'h22, 8'h00, 8'h0, 8'h0, 3'b100, 0, 0), "t5_read");
    drive_cycle(idle, "t5_idle");
    chk("t5_new_data", {24'b0, shadow[8'h22]}, 32'h7F);

    // 6: reset one cycle after a locked read
    do_reset();
    drive_cycle(mk(3'b010, 3'b010, 3'b000, 8'h00, 8'h05, 8'h00, 8'h0, 8'h0, 8'h0, 3'b010, 0, 0), "t6_read");
    rst = 1'b1;
    exp_q.delete();
    last_gaddr = '0;
    req = '0; lock = '0; we = '0;
    @(negedge clk);
    check_reset_values("t6_midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle(mk(3'b001, 3'b000, 3'b000, 8'h10, 8'h00, 8'h00, 8'h0, 8'h0, 8'h0, 3'b001, 0, 0), "t6_unlocked");
    drive_cycle(idle, "t6_idle");

    chk("sb_empty", 32'(exp_q.size()), 32'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sort_mem_arbiter.md
Name: sort_mem_arbiter

Overview:
- Shares the single-port 256x8 sort RAM (synchronous, registered inputs, 1-cycle read latency) between three requesters: the loader, the bubble-sort engine and the HEX/LEDR readback.
- Arbitrates every cycle and returns tagged read data.
- Supports a lock, so the sort engine's compare-swap sequence (read i, read i+1, write, write) is atomic.
- Sits between the requesters and the RAM instance inside the top-level sort design.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = loader, 1 = sort engine, 2 = readback).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (1 or 2).
- LOCK_TIMEOUT, 16, idle cycles after which an abandoned lock is force-released.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  access request per requester.
- lock  in  NUM_REQ  hold ownership after this access.
- we  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened write data.
- gnt  out  NUM_REQ  one-hot grant; the access is performed in the cycle where req[i]&gnt[i].
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_W  shared read data, qualified by rvalid.
- mem_addr  out  ADDR_W  to RAM address.
- mem_wren  out  1  to RAM write enable.
- mem_data  out  DATA_W  to RAM data input.
- mem_q  in  DATA_W  from RAM q.
- busy  out  1  a read is in flight, or the arbiter is LOCKED.
- lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values:
  - State OPEN; gnt = 0; rvalid = 0; rdata = 0.
  - mem_wren = 0; mem_addr = 0; mem_data = 0.
  - busy = 0; lock_err = 0.
  - Priority pointer = 0; idle counter = 0; read pipeline cleared.
- The grant is combinational from req and the registered state. At most one gnt bit is high per cycle. gnt is 0 when req is 0.
- mem_addr, mem_data and mem_wren are combinational muxes of the granted requester's addr, wdata and we. With no grant, mem_wren = 0 and mem_addr/mem_data hold the value of the last granted access.
- State OPEN:
  - The winner is chosen among req by the picker (see Optional Feature).
  - If the winner has lock=1 in its grant cycle: owner := winner, go to LOCKED next cycle.
- State LOCKED:
  - Only the owner can be granted (gnt[owner] = req[owner]); all other requests stall, with gnt = 0 for them.
  - Any cycle with lock[owner] = 0 releases ownership: return to OPEN next cycle. That cycle's access, if granted, still completes.
  - The idle counter increments each cycle with req[owner] = 0 and clears on any owner request.
  - When the counter reaches LOCK_TIMEOUT: force OPEN, pulse lock_err for 1 cycle, clear the counter.
- Reads: a granted read with we = 0 pushes the requester id into a RD_LAT-deep shift pipeline. After exactly RD_LAT cycles, rvalid[id] = 1 for one cycle and rdata = mem_q. Back-to-back reads from any mix of requesters give back-to-back rvalid pulses, in grant order.
- Writes produce no rvalid. A read granted in the cycle after a write to the same address returns the new data, because the RAM input is registered.
- busy = LOCKED, or any pipeline slot valid.
- Asynchronous reset mid-access: in-flight reads are dropped (no rvalid), the lock is released and the pointer returns to 0.

Optional Feature:
- Macro SORT_ARB_RR_EN.
- Defined: round-robin. Search starts at the pointer; after each grant in OPEN the pointer becomes winner+1 mod NUM_REQ. The pointer does not advance while LOCKED.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.
- Lock, timeout and read-latency behaviour are identical in both builds.

Decomposition:
- sort_pkg holds:
  - SORT_ADDR_W = 8, SORT_DATA_W = 8.
  - REQ_LOAD = 0, REQ_SORT = 1, REQ_DISP = 2.
  - arb_state_t enum {OPEN, LOCKED}.
- One combinational sub-module, sort_arb_pick: takes req and pointer, returns a one-hot winner. RR and fixed-priority variants are selected by SORT_ARB_RR_EN.

Test Plan:
1. Reset with all req = 0, then req[2] read addr 0x05, RAM[0x05] = 0xA3 -> gnt = 3'b100 the same cycle; rvalid = 3'b100 and rdata = 0xA3 exactly RD_LAT cycles later.
2. req = 3'b111 reads held for 6 cycles. RR build -> grants 0,1,2,0,1,2. Fixed build -> six grants to requester 0. In both builds, rvalid follows the same order.
3. Sort engine with lock = 1: reads 0x10, 0x11, writes 0x11 then 0x10 (lock = 0 on the final write), while req[0] and req[2] are held high -> only gnt[1] for the 4 cycles, then state OPEN; RAM[0x10]/RAM[0x11] swapped (e.g. 0x40/0x20 -> 0x20/0x40).
4. Requester 1 locks, then drops req with lock still 1 -> lock_err pulses after 16 idle cycles; the next cycle grants pending req[0].
5. Write 0x7F to 0x22, then read 0x22 from another requester in the next cycle -> rdata = 0x7F.
6. Assert rst one cycle after a granted read -> no rvalid, busy = 0, all outputs at reset values.
